sim_harness_seq: RTL and testbench
==================================

Name: sim_harness_seq

Overview:
- Parametrised run-control block for the simulation top; the successor to the single fixed DUT instance started by one test.
- Sequences staggered reset release for NUM_CH DUT channels.
- Watches a per-channel activity heartbeat.
- Reports run/pass/fail status the UVM test polls to end the run.
- Synthesisable RTL; sits between the top's clock/reset and the DUT channel instances.

Parameters:
NUM_CH, 4, number of DUT channels sequenced (1..16)
HOLD_CYC, 8, cycles all channel resets stay asserted after start (>=1)
STAGGER_CYC, 4, cycles between successive channel reset releases (>=1)
TIMEOUT_CYC, 1000, max idle cycles per enabled channel before fail (>=2)
CNT_W, 16, width of internal counters; must hold max(HOLD_CYC, STAGGER_CYC, TIMEOUT_CYC)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE, ignored otherwise
stop  in  1  one-cycle pulse; ends a run from RUN with pass
ch_en  in  NUM_CH  channel enable mask, sampled on the start cycle
activity  in  NUM_CH  per-channel heartbeat pulse from DUT
ch_rst  out  NUM_CH  active-high reset to each DUT channel
running  out  1  high while in RUN
done  out  1  high in DONE (pass)
fail  out  1  high in FAIL
fail_ch  out  $clog2(NUM_CH)+1  lowest-index timed-out channel; 0 when no fail

Behaviour:
- Reset values:
  - ch_rst all ones; running, done, fail = 0; fail_ch = 0; FSM = IDLE; counters = 0.
  - Reset asserted mid-run returns to these values immediately (async), regardless of state.
- States:
  - IDLE: ch_rst all ones. start -> HOLD, latch ch_en into en_q, clear counters.
  - HOLD: counts HOLD_CYC cycles, then -> RELEASE with channel index idx = 0.
  - RELEASE:
    - Walks idx 0..NUM_CH-1, one step every STAGGER_CYC cycles.
    - At each step, ch_rst[idx] deasserts if en_q[idx]; disabled channels stay in reset but still consume their slot.
    - After the last index -> RUN.
    - Channel k deasserts exactly HOLD_CYC + k*STAGGER_CYC cycles after the start cycle (registered output).
  - RUN:
    - running = 1.
    - Each enabled channel has an idle counter: cleared when activity[k] is high, otherwise incremented.
    - If any counter reaches TIMEOUT_CYC -> FAIL.
    - stop -> DONE.
    - If stop and a timeout occur in the same cycle, FAIL wins.
  - DONE: done = 1, all ch_rst reasserted. Next start -> HOLD (new run). Stays otherwise.
  - FAIL: fail = 1, fail_ch = lowest index k that timed out, plus 1. All ch_rst reasserted. Next start -> HOLD, clearing fail and fail_ch.
- Input filtering:
  - start outside IDLE/DONE/FAIL is ignored.
  - stop outside RUN is ignored.
  - activity on disabled channels or outside RUN is ignored.
- Empty mask: en_q == 0 still walks HOLD and RELEASE, enters RUN, never times out; only stop exits.
- Counters saturate; no wrap-around.

Optional Feature:
- Macro: SIM_HARNESS_WATCHDOG_EN.
- Defined: RUN-state idle counters, FAIL state, fail and fail_ch operate as above.
- Undefined:
  - No idle counters are built; activity is unused.
  - fail and fail_ch are tied to 0; FAIL is unreachable.
  - RUN exits only on stop.

Test Plan:
1. rst, then start with ch_en=4'b1111, defaults, activity pulsed every 10 cycles -> ch_rst[0..3] fall at start+8, +12, +16, +20; running rises at start+20..+24; later stop -> done=1, ch_rst=4'b1111.
2. ch_en=4'b0101 -> only ch_rst[0] and ch_rst[2] fall (at +8, +16); ch_rst[1] and ch_rst[3] stay high; activity on ch1 is ignored.
3. In RUN, stop pulsing activity[2] only (TIMEOUT_CYC=20) -> fail=1, fail_ch=3 exactly 20 cycles after the last ch2 pulse.
4. stop and timeout in the same cycle -> fail=1, done=0.
5. Assert rst during RELEASE after ch0 has released -> ch_rst returns to all ones and running=0 immediately; a new start restarts the HOLD count from 0.
6. Build without SIM_HARNESS_WATCHDOG_EN, with no activity for 5000 cycles -> fail stays 0, running stays 1; stop -> done=1.

Source files
------------

// File: rtl/sim_harness_seq.sv
// sim_harness_seq: staggered channel reset release, heartbeat watchdog and run status (optional SIM_HARNESS_WATCHDOG_EN)
module sim_harness_seq #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYC    = 8,
    parameter int STAGGER_CYC = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH-1:0]         activity,
    output logic [NUM_CH-1:0]         ch_rst,
    output logic                      running,
    output logic                      done,
    output logic                      fail,
    output logic [$clog2(NUM_CH):0]   fail_ch
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int FW = $clog2(NUM_CH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_REL, S_RUN, S_DONE, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
    logic [FW-1:0]     fail_ch_q, fail_ch_d;
    logic              timeout;
    logic [FW-1:0]     hit_ch;

`ifdef SIM_HARNESS_WATCHDOG_EN
    logic [NUM_CH-1:0][CNT_W-1:0] idle_q, idle_d;
    logic [NUM_CH-1:0]            hit;

    // per-channel idle counters; a hit flags the cycle a counter would reach the timeout
    always_comb begin
        idle_d = idle_q;
        hit    = '0;
        hit_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = state_q == S_RUN && en_q[k] && !activity[k] && idle_q[k] == CNT_W'(TIMEOUT_CYC - 1);
            if (start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL))
                idle_d[k] = '0;
            else if (state_q == S_RUN && en_q[k])
                idle_d[k] = activity[k] ? '0 : (idle_q[k] == CNT_W'(TIMEOUT_CYC) ? idle_q[k] : idle_q[k] + 1'b1);
        end
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (hit[k]) hit_ch = FW'(k + 1);
    end

    assign timeout = |hit;

    // idle counter registers
    always_ff @(posedge clk or posedge rst)
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
`else
    logic unused_activity;
    assign unused_activity = ^activity;
    assign timeout         = 1'b0;
    assign hit_ch          = '0;
`endif

    // sequencer next state: hold, staggered release walk, run supervision, terminal states
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        en_d      = en_q;
        ch_rst_d  = ch_rst_q;
        fail_ch_d = fail_ch_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL:
                if (start) begin
                    state_d   = S_HOLD;
                    en_d      = ch_en;
                    cnt_d     = '0;
                    idx_d     = '0;
                    fail_ch_d = '0;
                    ch_rst_d  = '1;
                end
            S_HOLD:
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d     = S_REL;
                    cnt_d       = '0;
                    idx_d       = '0;
                    ch_rst_d[0] = !en_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            S_REL:
                if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IW'(NUM_CH - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d           = idx_q + 1'b1;
                        ch_rst_d[idx_d] = !en_q[idx_d];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            S_RUN:
                if (timeout) begin
                    state_d   = S_FAIL;
                    fail_ch_d = hit_ch;
                    ch_rst_d  = '1;
                end else if (stop) begin
                    state_d  = S_DONE;
                    ch_rst_d = '1;
                end
            default: state_d = S_IDLE;
        endcase
    end

    // sequencer registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            en_q      <= '0;
            ch_rst_q  <= '1;
            fail_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            en_q      <= en_d;
            ch_rst_q  <= ch_rst_d;
            fail_ch_q <= fail_ch_d;
        end

    assign ch_rst  = ch_rst_q;
    assign running = state_q == S_RUN;
    assign done    = state_q == S_DONE;
    assign fail    = state_q == S_FAIL;
    assign fail_ch = fail_ch_q;
endmodule

// File: tb/tb_sim_harness_seq.sv
// tb_sim_harness_seq: directed stimulus with a timeline-based reference model for sim_harness_seq
module tb_sim_harness_seq;
    localparam int N  = 4;
    localparam int H  = 8;
    localparam int S  = 4;
    localparam int TO = 20;
    localparam int FW = 3;

    logic          clk = 0, rst = 1, start = 0, stop = 0;
    logic [N-1:0]  ch_en = '0, activity = '0, man_act = '0;
    logic          auto_act = 0;
    logic [N-1:0]  ch_rst;
    logic          running, done, fail;
    logic [FW-1:0] fail_ch;

    int total = 0, bad = 0, ac = 0;

    // reference model: run timeline measured in cycles since the start edge
    bit           m_busy = 0;
    int           m_t = 0, m_res = 0, m_fch = 0, m_hit = 0;
    logic [N-1:0] m_en = '0, e_rst;
    int           m_idle [N];

    sim_harness_seq #(.NUM_CH(N), .HOLD_CYC(H), .STAGGER_CYC(S), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ch_en(ch_en), .activity(activity),
        .ch_rst(ch_rst), .running(running), .done(done), .fail(fail), .fail_ch(fail_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [N-1:0] en);
        @(negedge clk);
        ch_en = en;
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1;
        @(posedge clk);
        #1 stop = 0;
    endtask

    initial forever begin
        @(negedge clk);
        ac++;
        activity = auto_act ? ((ac % 10 == 0) ? 4'hF : 4'h0) : man_act;
    end

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_t = 0; m_en = '0; m_res = 0; m_fch = 0;
            for (int k = 0; k < N; k++) m_idle[k] = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_t = 0; m_en = ch_en; m_res = 0; m_fch = 0;
                for (int k = 0; k < N; k++) m_idle[k] = 0;
            end
        end else begin
            if (m_t >= H + N * S) begin
                m_hit = 0;
`ifdef SIM_HARNESS_WATCHDOG_EN
                for (int k = 0; k < N; k++)
                    if (m_en[k]) begin
                        m_idle[k] = activity[k] ? 0 : m_idle[k] + 1;
                        if (m_idle[k] >= TO && m_hit == 0) m_hit = k + 1;
                    end
`endif
                if (m_hit != 0) begin
                    m_busy = 0; m_res = 2; m_fch = m_hit;
                end else if (stop) begin
                    m_busy = 0; m_res = 1;
                end
            end
            m_t++;
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) e_rst[k] = !(m_busy && m_en[k] && m_t >= H + k * S);
        check("m_ch_rst", 32'(ch_rst), 32'(e_rst));
        check("m_running", 32'(running), 32'(m_busy && m_t >= H + N * S));
        check("m_done", 32'(done), 32'(!m_busy && m_res == 1));
        check("m_fail", 32'(fail), 32'(!m_busy && m_res == 2));
        check("m_fail_ch", 32'(fail_ch), 32'(m_fch));
    end

    initial begin
        step(3);
        rst = 0;
        check("rst_ch_rst", 32'(ch_rst), 32'hF);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fail_ch", 32'(fail_ch), 0);

        auto_act = 1;
        pulse_start(4'hF);
        step(7);  check("t1_t7", 32'(ch_rst), 32'hF);
        step(1);  check("t1_t8", 32'(ch_rst), 32'hE);
        step(4);  check("t1_t12", 32'(ch_rst), 32'hC);
        step(4);  check("t1_t16", 32'(ch_rst), 32'h8);
        step(4);  check("t1_t20", 32'(ch_rst), 32'h0);
        check("t1_run20", 32'(running), 0);
        step(3);  check("t1_run23", 32'(running), 0);
        step(1);  check("t1_run24", 32'(running), 1);
        step(30);
        pulse_stop();
        check("t1_done", 32'(done), 1);
        check("t1_rst_back", 32'(ch_rst), 32'hF);

        pulse_start(4'b0101);
        step(2);
        pulse_stop();
        step(4);  check("t2_t7", 32'(ch_rst), 32'hF);
        step(1);  check("t2_t8", 32'(ch_rst), 32'hE);
        step(4);  check("t2_t12", 32'(ch_rst), 32'hE);
        step(4);  check("t2_t16", 32'(ch_rst), 32'hA);
        step(4);  check("t2_t20", 32'(ch_rst), 32'hA);
        step(10); check("t2_running", 32'(running), 1);
        pulse_start(4'hF);
        step(5);  check("t2_ignore_start", 32'(ch_rst), 32'hA);
        pulse_stop();
        check("t2_done", 32'(done), 1);

`ifdef SIM_HARNESS_WATCHDOG_EN
        pulse_start(4'hF);
        step(40);
        auto_act = 0; man_act = 4'hF;
        @(posedge clk); #1;
        man_act = 4'b1011;
        step(19); check("t3_pre", 32'(fail), 0);
        step(1);  check("t3_fail", 32'(fail), 1);
        check("t3_fail_ch", 32'(fail_ch), 3);
        check("t3_ch_rst", 32'(ch_rst), 32'hF);
        auto_act = 1;
        pulse_start(4'hF);
        check("t3_clr_fail", 32'(fail), 0);
        check("t3_clr_ch", 32'(fail_ch), 0);
        step(40);
        auto_act = 0; man_act = 4'hF;
        @(posedge clk); #1;
        man_act = 4'b1011;
        step(19);
        pulse_stop();
        check("t4_fail", 32'(fail), 1);
        check("t4_done", 32'(done), 0);
        check("t4_fail_ch", 32'(fail_ch), 3);
        man_act = 4'h0;
`endif

        pulse_start(4'h0);
        auto_act = 0; man_act = 4'h0;
        step(H + N * S + 50);
        check("empty_running", 32'(running), 1);
        check("empty_fail", 32'(fail), 0);
        check("empty_ch_rst", 32'(ch_rst), 32'hF);
        pulse_stop();
        check("empty_done", 32'(done), 1);

        auto_act = 1;
        pulse_start(4'hF);
        step(9);  check("t5_pre", 32'(ch_rst), 32'hE);
        rst = 1;
        #1;
        check("t5_async_rst", 32'(ch_rst), 32'hF);
        check("t5_async_run", 32'(running), 0);
        step(2);
        rst = 0;
        pulse_start(4'hF);
        step(7);  check("t5_t7", 32'(ch_rst), 32'hF);
        step(1);  check("t5_t8", 32'(ch_rst), 32'hE);
        step(30);
        pulse_stop();
        check("t5_done", 32'(done), 1);

`ifndef SIM_HARNESS_WATCHDOG_EN
        pulse_start(4'hF);
        auto_act = 0; man_act = 4'h0;
        step(5000);
        check("t6_running", 32'(running), 1);
        check("t6_fail", 32'(fail), 0);
        pulse_stop();
        check("t6_done", 32'(done), 1);
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
